// File: rtl/hardware.sv
`timescale 1ns/1ps
// 1024 x 8 storage array with combinational read and a write on the rising edge.
// Read data follows the address in the same cycle. There is no flow control; a write occurs on every edge with we_i set.
module hardware_mem (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [9:0] addr_i,
  input  logic [7:0] wdat_i,
  output logic [7:0] rdat_o
);

  reg [7:0] mem [0:1023];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdat_i;
  end

  assign rdat_o = mem[addr_i];

endmodule

// CPU-side bus glue: xclk divider, power-up and reset CLEAR, 1 KiB RAM, and an LED register at 0x0FF.
// Read data appears one clk_16mhz cycle after nmrd falls. The bus has no backpressure, and nwait is tied inactive.
module hardware (
  input  logic       clk_16mhz,
  input  logic       reset,
  output logic       pin_1,
  output logic       pin_2,
  output logic       pin_3,
  input  logic       pin_4,
  input  logic       pin_5,
  input  logic       pin_6,
  input  logic       pin_7,
  input  logic       pin_8,
  input  logic       pin_9,
  input  logic       pin_10,
  input  logic       pin_11,
  input  logic       pin_12,
  input  logic       pin_13,
  input  logic       pin_14,
  input  logic       pin_15,
  inout  wire        pin_16,
  inout  wire        pin_17,
  inout  wire        pin_18,
  inout  wire        pin_19,
  inout  wire        pin_20,
  inout  wire        pin_21,
  inout  wire        pin_22,
  inout  wire        pin_23,
  output logic [7:0] leds
);

  // Declaration initialisers give the power-up CLEAR pulse when no reset pulse is applied.
  logic [1:0] xclk_cnt_q = 2'd0;
  logic [1:0] xclk_cnt_d;
  logic [6:0] clr_cnt_q  = 7'd0;
  logic [6:0] clr_cnt_d;
  logic [1:0] hi_q, hi_d;
  logic [7:0] dout_q, dout_d;
  logic       nmrd_q, nmrd_d;
  logic [7:0] leds_q, leds_d;

  logic [7:0] ma;
  logic [7:0] db_in;
  logic [7:0] mem_rdat;
  logic [9:0] addr;
  logic       mem_we;
  logic       db_oe;
  logic       unused_tpb;

  assign ma         = {pin_15, pin_14, pin_13, pin_12, pin_11, pin_10, pin_9, pin_8};
  assign db_in      = {pin_23, pin_22, pin_21, pin_20, pin_19, pin_18, pin_17, pin_16};
  // Only hi[1:0] reaches the address, so the 1 KiB repeats through 64 KiB.
  assign addr       = {hi_q, ma};
  assign mem_we     = ~pin_4;
  assign db_oe      = ~nmrd_q & pin_4;
  assign unused_tpb = pin_7;

  hardware_mem memory (
    .clk_i  (clk_16mhz),
    .we_i   (mem_we),
    .addr_i (addr),
    .wdat_i (db_in),
    .rdat_o (mem_rdat)
  );

  always_comb begin
    xclk_cnt_d = xclk_cnt_q + 2'd1;
    clr_cnt_d  = clr_cnt_q[6] ? clr_cnt_q : clr_cnt_q + 7'd1;
    hi_d       = pin_6 ? ma[1:0] : hi_q;
    dout_d     = ~pin_5 ? mem_rdat : dout_q;
    nmrd_d     = pin_5;
    leds_d     = (mem_we && addr == 10'h0FF) ? db_in : leds_q;
  end

  // A floating reset evaluates as unknown and takes the run branch. The memory write is deliberately outside reset.
  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      xclk_cnt_q <= 2'd0;
      clr_cnt_q  <= 7'd0;
      hi_q       <= 2'd0;
      dout_q     <= 8'h00;
      nmrd_q     <= 1'b1;
      leds_q     <= 8'h00;
    end else begin
      xclk_cnt_q <= xclk_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      hi_q       <= hi_d;
      dout_q     <= dout_d;
      nmrd_q     <= nmrd_d;
      leds_q     <= leds_d;
    end
  end

  assign pin_1  = xclk_cnt_q[1];
  assign pin_2  = 1'b1;
  assign pin_3  = clr_cnt_q[6];
  assign leds   = leds_q;

  assign pin_16 = db_oe ? dout_q[0] : 1'bz;
  assign pin_17 = db_oe ? dout_q[1] : 1'bz;
  assign pin_18 = db_oe ? dout_q[2] : 1'bz;
  assign pin_19 = db_oe ? dout_q[3] : 1'bz;
  assign pin_20 = db_oe ? dout_q[4] : 1'bz;
  assign pin_21 = db_oe ? dout_q[5] : 1'bz;
  assign pin_22 = db_oe ? dout_q[6] : 1'bz;
  assign pin_23 = db_oe ? dout_q[7] : 1'bz;

endmodule

// File: tb/tb_hardware.sv
`timescale 1ns/1ps
// Directed and random CPU bus cycles checked against a byte-array model of the RAM, the LED register and the CLEAR/xclk timing.
// The data lines are pulled up, so an undriven bus reads 0xFF. RAM contents stay below 0xFF so that value only means high-Z.
module tb_hardware;

  logic       clk = 1'b0;
  logic       reset;
  logic       nmwr, nmrd, tpa, tpb;
  logic [7:0] ma;
  logic       tb_drv;
  logic [7:0] tb_dat;
  wire        xclk, nwait, clr;
  wire  [7:0] leds;
  wire        d0, d1, d2, d3, d4, d5, d6, d7;
  wire  [7:0] db = {d7, d6, d5, d4, d3, d2, d1, d0};

  assign d0 = tb_drv ? tb_dat[0] : 1'bz;
  assign d1 = tb_drv ? tb_dat[1] : 1'bz;
  assign d2 = tb_drv ? tb_dat[2] : 1'bz;
  assign d3 = tb_drv ? tb_dat[3] : 1'bz;
  assign d4 = tb_drv ? tb_dat[4] : 1'bz;
  assign d5 = tb_drv ? tb_dat[5] : 1'bz;
  assign d6 = tb_drv ? tb_dat[6] : 1'bz;
  assign d7 = tb_drv ? tb_dat[7] : 1'bz;
  pullup (d0);
  pullup (d1);
  pullup (d2);
  pullup (d3);
  pullup (d4);
  pullup (d5);
  pullup (d6);
  pullup (d7);

  hardware dut (
    .clk_16mhz (clk),
    .reset     (reset),
    .pin_1     (xclk),
    .pin_2     (nwait),
    .pin_3     (clr),
    .pin_4     (nmwr),
    .pin_5     (nmrd),
    .pin_6     (tpa),
    .pin_7     (tpb),
    .pin_8     (ma[0]),
    .pin_9     (ma[1]),
    .pin_10    (ma[2]),
    .pin_11    (ma[3]),
    .pin_12    (ma[4]),
    .pin_13    (ma[5]),
    .pin_14    (ma[6]),
    .pin_15    (ma[7]),
    .pin_16    (d0),
    .pin_17    (d1),
    .pin_18    (d2),
    .pin_19    (d3),
    .pin_20    (d4),
    .pin_21    (d5),
    .pin_22    (d6),
    .pin_23    (d7),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  // Reference model: plain RAM contents, the LED byte and the last latched high byte.
  logic [7:0] model_mem [1024];
  logic [7:0] model_leds;
  int         model_hi;
  int         n_checks;
  int         n_err;
  int         zeros;
  int         op;
  int         lo;
  int         v;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ea(input int lo_addr);
    return (model_hi % 4) * 256 + lo_addr;
  endfunction

  task automatic latch_hi(input int h);
    ma  = h[7:0];
    tpa = 1'b1;
    step();
    tpa = 1'b0;
    model_hi = h;
  endtask

  task automatic cpu_read(input int lo_addr, input string tag);
    int a;
    a    = ea(lo_addr);
    ma   = lo_addr[7:0];
    nmrd = 1'b0;
    #1;
    check({tag, " before edge"}, db, 8'hFF);
    step();
    check(tag, db, model_mem[a]);
    nmrd = 1'b1;
    step();
    check({tag, " released"}, db, 8'hFF);
  endtask

  task automatic cpu_write(input int lo_addr, input int val);
    int a;
    a      = ea(lo_addr);
    ma     = lo_addr[7:0];
    tb_dat = val[7:0];
    tb_drv = 1'b1;
    nmwr   = 1'b0;
    model_mem[a] = val[7:0];
    if (a == 'h0FF) model_leds = val[7:0];
    step();
    check("leds after write edge", leds, model_leds);
    repeat (3) step();
    nmwr   = 1'b0;
    nmwr   = 1'b1;
    tb_drv = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b0;
    nmwr     = 1'b1;
    nmrd     = 1'b1;
    tpa      = 1'b0;
    tpb      = 1'b0;
    ma       = 8'h00;
    tb_drv   = 1'b0;
    tb_dat   = 8'h00;
    model_hi = 0;
    model_leds = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      v = (i < 8) ? i : int'($urandom_range(0, 254));
      dut.memory.mem[i] = v[7:0];
      model_mem[i] = v[7:0];
    end

    // Power-up without any reset pulse.
    #1;
    zeros = (clr == 1'b0) ? 1 : 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (clr == 1'b0) zeros++;
      check("powerup nwait", nwait, 1'b1);
    end
    check("powerup clr low cycles", zeros, 64);
    check("powerup clr final", clr, 1'b1);

    // Reset state, with a nonzero high byte latched beforehand.
    latch_hi(3);
    reset = 1'b1;
    repeat (2) step();
    model_hi   = 0;
    model_leds = 8'h00;
    check("reset xclk", xclk, 1'b0);
    check("reset clr", clr, 1'b0);
    check("reset nwait", nwait, 1'b1);
    check("reset leds", leds, 8'h00);
    check("reset db hiz", db, 8'hFF);

    // xclk divide-by-4 and the 64-cycle CLEAR after reset release.
    reset = 1'b0;
    zeros = (clr == 1'b0) ? 1 : 0;
    check("xclk k=0", xclk, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      step();
      if (clr == 1'b0) zeros++;
      check("xclk phase", xclk, ((k % 4) >= 2) ? 1'b1 : 1'b0);
      check("nwait", nwait, 1'b1);
    end
    check("clr low cycles", zeros, 64);
    check("clr final", clr, 1'b1);

    // Basic read, write and readback; hi was cleared by reset.
    latch_hi(0);
    cpu_read(3, "read 0x003");
    check("read 0x003 const", model_mem[3], 8'h03);
    cpu_write('h10, 'h5A);
    cpu_read('h10, "read 0x010");
    check("mem dump 0x010", dut.memory.mem[16], 8'h5A);

    // High byte aliasing: only hi[1:0] selects the page.
    latch_hi(1);
    cpu_read(2, "read 0x102");
    latch_hi(5);
    cpu_read(2, "read alias hi=05");
    cpu_write(2, 'h6B);
    latch_hi('hFD);
    cpu_read(2, "read alias hi=FD");

    // Read and write strobed together: the write wins and the DUT stays off the bus.
    latch_hi(0);
    ma     = 8'h20;
    tb_dat = 8'h3C;
    tb_drv = 1'b1;
    nmwr   = 1'b0;
    nmrd   = 1'b0;
    step();
    check("rd+wr bus not driven", db, 8'h3C);
    nmwr   = 1'b1;
    nmrd   = 1'b1;
    tb_drv = 1'b0;
    model_mem['h20] = 8'h3C;
    step();
    cpu_read('h20, "read after rd+wr");

    // LED register at 0x0FF, cleared by reset while the RAM copy survives.
    cpu_write('hFF, 'hA5);
    check("leds 0xA5", leds, 8'hA5);
    reset = 1'b1;
    step();
    model_leds = 8'h00;
    model_hi   = 0;
    check("leds after reset", leds, 8'h00);
    reset = 1'b0;
    cpu_read('hFF, "read 0x0FF after reset");

    // Reset in the middle of a read cycle drops the bus on the next edge.
    ma   = 8'h05;
    nmrd = 1'b0;
    step();
    check("read before abort", db, model_mem[5]);
    reset = 1'b1;
    step();
    check("db after reset abort", db, 8'hFF);
    nmrd  = 1'b1;
    reset = 1'b0;
    model_hi = 0;
    step();

    // Randomized mix of high-byte latches, writes and reads.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      lo = ($urandom_range(0, 3) == 0) ? 'hFF : int'($urandom_range(0, 255));
      if (op == 0) begin
        latch_hi($urandom_range(0, 255));
      end else if (op == 1) begin
        cpu_write(lo, $urandom_range(0, 254));
      end else begin
        cpu_read(lo, "random read");
      end
    end
    check("leds after random", leds, model_leds);

    // Long idle: bus stays released and memory is untouched.
    for (int k = 0; k < 1000; k++) begin
      step();
      check("idle db hiz", db, 8'hFF);
    end
    for (int i = 0; i < 1024; i++) begin
      check("final mem contents", dut.memory.mem[i], model_mem[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hardware.md
HARDWARE -- requirements
Module: hardware

Interface
REQ-001 The module SHALL have no parameters; memory depth is fixed at 1024 x 8 bits.
REQ-002 clk_16mhz  input  1  system clock; all logic is synchronous to its rising edge.
REQ-003 reset  input  1  synchronous active-high reset; an unconnected or Z level SHALL act as deasserted.
REQ-004 pin_1 (xclk)  output  1  CPU clock = clk_16mhz / 4, 50% duty cycle.
REQ-005 pin_2 (nwait)  output  1  CPU WAIT, active low; held at 1 (no wait states).
REQ-006 pin_3 (clr)  output  1  CPU CLEAR, active low.
REQ-007 pin_4 (nmwr)  input  1  CPU memory write strobe, active low.
REQ-008 pin_5 (nmrd)  input  1  CPU memory read strobe, active low.
REQ-009 pin_6 (tpa), pin_7 (tpb)  input  1 each  CPU timing pulses A and B.
REQ-010 pin_8..pin_15 (ma0..ma7)  input  8  multiplexed CPU address; pin_8 is the LSB.
REQ-011 pin_16..pin_23 (db0..db7)  inout  8  CPU data bus; pin_16 is the LSB.
REQ-012 leds  output  8  LED register.

Function
REQ-013 The storage array SHALL be an instance named memory containing reg array mem[0:1023] of 8-bit words, so a bench can preload it hierarchically.
REQ-014 Memory contents SHALL NOT be altered by reset.
REQ-015 xclk SHALL be produced by a 2-bit free-running counter: low for 2 clk_16mhz cycles, then high for 2.
REQ-016 While tpa = 1 on a clock edge, the high-address register SHALL load ma[7:0]; it SHALL hold its value while tpa = 0.
REQ-017 Effective address = {hi[1:0], ma[7:0]}; hi[7:2] SHALL be ignored, so the 1 KiB is aliased through 64 KiB.
REQ-018 Read: on every edge with nmrd = 0, the module SHALL register mem[addr] into the output data register. This gives 1 clk_16mhz cycle of latency.
REQ-019 db SHALL be driven with the output data register whenever the registered nmrd is 0 and nmwr = 1; otherwise db SHALL be high-Z.
REQ-020 Write: on every edge with nmwr = 0, the module SHALL write db into mem[addr].
REQ-021 When nmrd = 0 and nmwr = 0 at the same time, the write SHALL take effect, and db SHALL NOT be driven.
REQ-022 A write with effective address 0x0FF SHALL also load leds with the db value.
REQ-023 The address-0x0FF location SHALL also be stored in mem, so reads return the written value.
REQ-024 clr SHALL be 0 for 16 full xclk periods after reset is released (64 clk_16mhz cycles), then 1 until the next reset.
REQ-025 At power-up, without an explicit reset pulse, clr SHALL be held 0 for 64 cycles by an internal initial counter value.

Reset
REQ-026 While reset = 1, these SHALL apply:
  - xclk counter = 0, so xclk = 0;
  - clr = 0, and the clr counter restarts;
  - nwait = 1;
  - leds = 0x00;
  - high-address register = 0x00;
  - output data register = 0x00;
  - db = high-Z.
REQ-027 Asserting reset during a CPU bus cycle SHALL abort any drive of db on the next edge, and SHALL NOT corrupt memory other than a write already strobed.

Verification
REQ-028 Preload mem[i] = i for i = 0..7. Run a CPU read cycle with tpa=1 and ma=0x00, then ma=0x03 and nmrd=0. Required: db = 0x03 one clock after nmrd falls, and db = high-Z after nmrd rises.
REQ-029 Write 0x5A at address 0x0010 with nmwr=0 for one xclk period, then read back. Required: db = 0x5A, and the mem[0x010] dump shows 0x5A.
REQ-030 Latch hi=0x01 via tpa, then read with ma=0x02. Required: data of mem[0x102]. Latch hi=0x05, then read with ma=0x02. Required: same data (alias).
REQ-031 After reset: xclk period = 4 clk_16mhz cycles; nwait stays 1 throughout; clr = 0 for exactly 64 cycles, then 1.
REQ-032 Write 0xA5 to address 0x00FF. Required: leds = 0xA5 on the next clock. Then assert reset. Required: leds = 0x00, and mem[0x0FF] still reads 0xA5.
REQ-033 Hold nmrd = 1 and nmwr = 1 for 1000 cycles. Required: db remains high-Z, and memory is unchanged.
